// File: rtl/pipe_skid_reg_pkg.sv
// Constants shared by every pipeline stage register: occupancy-state encoding
// and the default bubble (NOP) payload.
package pipe_skid_reg_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   localparam logic [63:0] PIPE_BUBBLE = 64'h0;

   function automatic logic [1:0] occupancy(input logic [1:0] st);
      case (st)
         ST_ONE:  occupancy = 2'd1;
         ST_FULL: occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register: two-entry skid buffer (SKID=1, registered
// in_ready) or single entry with pass-through ready (SKID=0). Flush empties it.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int              WIDTH  = 64,
   parameter bit              SKID   = 1'b1,
   parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PIPE_BUBBLE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_count
);

   generate
      if (SKID) begin : g_skid
         logic [1:0]       state_q, state_d;
         logic [WIDTH-1:0] main_q, main_d;
         logic [WIDTH-1:0] skid_q, skid_d;
         logic             rdy_q;
         logic             do_acc, do_rel;

         assign do_acc = in_valid && rdy_q;
         assign do_rel = (state_q != ST_EMPTY) && out_ready;

         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush) begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE;
               skid_d  = BUBBLE;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (do_acc) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                     end
                  end
                  ST_ONE: begin
                     if (do_acc && do_rel) begin
                        main_d = in_data;
                     end else if (do_acc) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                     end else if (do_rel) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                     end
                  end
                  ST_FULL: begin
                     // in_ready is low here, so only the drain path exists
                     if (do_rel) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                     end
                  end
                  default: begin
                     state_d = ST_EMPTY;
                     main_d  = BUBBLE;
                     skid_d  = BUBBLE;
                  end
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_q <= ST_EMPTY;
               main_q  <= BUBBLE;
               skid_q  <= BUBBLE;
               rdy_q   <= 1'b1;
            end else begin
               state_q <= state_d;
               main_q  <= main_d;
               skid_q  <= skid_d;
               rdy_q   <= (state_d != ST_FULL);
            end
         end

         assign in_ready  = rdy_q;
         assign out_valid = (state_q != ST_EMPTY);
         assign out_data  = out_valid ? main_q : BUBBLE;
         assign out_count = occupancy(state_q);
      end else begin : g_pass
         logic [1:0]       state_q, state_d;
         logic [WIDTH-1:0] main_q, main_d;
         logic             do_acc, do_rel;

         assign do_acc = in_valid && in_ready;
         assign do_rel = (state_q != ST_EMPTY) && out_ready;

         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            if (flush) begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE;
            end else if (do_acc) begin
               state_d = ST_ONE;
               main_d  = in_data;
            end else if (do_rel) begin
               state_d = ST_EMPTY;
               main_d  = BUBBLE;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               state_q <= ST_EMPTY;
               main_q  <= BUBBLE;
            end else begin
               state_q <= state_d;
               main_q  <= main_d;
            end
         end

         assign in_ready  = (state_q == ST_EMPTY) || out_ready;
         assign out_valid = (state_q != ST_EMPTY);
         assign out_data  = out_valid ? main_q : BUBBLE;
         assign out_count = occupancy(state_q);
      end
   endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus hand sequences and a random queue scoreboard for
// both SKID modes of pipe_skid_reg.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        reset;

   logic        r_iv, r_fl, r_or, r_ir, r_ov;
   logic [63:0] r_d, r_od;
   logic [1:0]  r_cnt;

   logic        p_iv, p_fl, p_or, p_ir, p_ov;
   logic [63:0] p_d, p_od;
   logic [1:0]  p_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.WIDTH(64), .SKID(1'b1)) u_skid (
      .clk(clk), .reset(reset),
      .in_valid(r_iv), .in_ready(r_ir), .in_data(r_d), .flush(r_fl),
      .out_valid(r_ov), .out_ready(r_or), .out_data(r_od), .out_count(r_cnt));

   pipe_skid_reg #(.WIDTH(64), .SKID(1'b0)) u_pass (
      .clk(clk), .reset(reset),
      .in_valid(p_iv), .in_ready(p_ir), .in_data(p_d), .flush(p_fl),
      .out_valid(p_ov), .out_ready(p_or), .out_data(p_od), .out_count(p_cnt));

   typedef struct {
      logic        iv;
      logic [63:0] d;
      logic        fl;
      logic        orr;
      logic        ov;
      logic [63:0] od;
      logic [1:0]  cnt;
      logic        ir;
   } vec_t;

   function automatic vec_t mk(logic iv, logic [63:0] d, logic fl, logic orr,
                               logic ov, logic [63:0] od, logic [1:0] cnt, logic ir);
      vec_t v;
      v.iv = iv; v.d = d; v.fl = fl; v.orr = orr;
      v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_skid(input string tag, input logic ov, input logic [63:0] od,
                           input logic [1:0] cnt, input logic ir);
      chk({tag, ".out_valid"}, 64'(r_ov), 64'(ov));
      chk({tag, ".out_data"},  r_od, od);
      chk({tag, ".out_count"}, 64'(r_cnt), 64'(cnt));
      chk({tag, ".in_ready"},  64'(r_ir), 64'(ir));
   endtask

   task automatic chk_pass(input string tag, input logic ov, input logic [63:0] od,
                           input logic [1:0] cnt, input logic ir);
      chk({tag, ".out_valid"}, 64'(p_ov), 64'(ov));
      chk({tag, ".out_data"},  p_od, od);
      chk({tag, ".out_count"}, 64'(p_cnt), 64'(cnt));
      chk({tag, ".in_ready"},  64'(p_ir), 64'(ir));
   endtask

   vec_t vt[20];
   logic [63:0] q1[$];
   logic [63:0] q0[$];

   initial begin
      // iv  d     fl orr   ov  od    cnt ir
      vt[0]  = mk(1, 64'd1, 0, 1,   1, 64'd1, 1, 1);
      vt[1]  = mk(1, 64'd2, 0, 1,   1, 64'd2, 1, 1);
      vt[2]  = mk(1, 64'd3, 0, 1,   1, 64'd3, 1, 1);
      vt[3]  = mk(1, 64'd4, 0, 1,   1, 64'd4, 1, 1);
      vt[4]  = mk(1, 64'd5, 0, 1,   1, 64'd5, 1, 1);
      vt[5]  = mk(0, 64'd0, 0, 1,   0, 64'd0, 0, 1);
      vt[6]  = mk(1, 64'd7, 0, 0,   1, 64'd7, 1, 1);
      vt[7]  = mk(1, 64'd8, 0, 0,   1, 64'd7, 2, 0);
      vt[8]  = mk(1, 64'd9, 0, 0,   1, 64'd7, 2, 0);
      vt[9]  = mk(1, 64'd9, 0, 1,   1, 64'd8, 1, 1);
      vt[10] = mk(1, 64'd9, 0, 1,   1, 64'd9, 1, 1);
      vt[11] = mk(0, 64'd0, 0, 1,   0, 64'd0, 0, 1);
      vt[12] = mk(1, 64'd7, 0, 0,   1, 64'd7, 1, 1);
      vt[13] = mk(1, 64'd8, 0, 0,   1, 64'd7, 2, 0);
      vt[14] = mk(1, 64'd9, 1, 0,   0, 64'd0, 0, 1);
      vt[15] = mk(0, 64'd0, 0, 1,   0, 64'd0, 0, 1);
      vt[16] = mk(1, 64'hAA, 1, 1,  0, 64'd0, 0, 1);
      vt[17] = mk(1, 64'hB, 0, 0,   1, 64'hB, 1, 1);
      vt[18] = mk(0, 64'd0, 0, 0,   1, 64'hB, 1, 1);
      vt[19] = mk(0, 64'd0, 1, 1,   0, 64'd0, 0, 1);

      // reset held two cycles while upstream offers data
      reset = 1'b1;
      r_iv = 1'b1; r_d = 64'hA; r_fl = 1'b0; r_or = 1'b0;
      p_iv = 1'b1; p_d = 64'hA; p_fl = 1'b0; p_or = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_skid("reset_skid", 0, 64'd0, 0, 1);
      chk_pass("reset_pass", 0, 64'd0, 0, 1);
      @(negedge clk);
      reset = 1'b0; r_iv = 1'b0; p_iv = 1'b0;
      @(posedge clk); #1;
      chk_skid("post_reset_skid", 0, 64'd0, 0, 1);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         r_iv = vt[i].iv; r_d = vt[i].d; r_fl = vt[i].fl; r_or = vt[i].orr;
         @(posedge clk); #1;
         chk_skid($sformatf("vec%0d", i), vt[i].ov, vt[i].od, vt[i].cnt, vt[i].ir);
      end

      // SKID=0: ready passes through combinationally
      @(negedge clk);
      r_iv = 1'b0; r_fl = 1'b0; r_or = 1'b0;
      p_iv = 1'b1; p_d = 64'd3; p_or = 1'b0;
      @(posedge clk); #1;
      chk_pass("pass_hold3", 1, 64'd3, 1, 0);
      @(negedge clk);
      p_iv = 1'b0; p_or = 1'b0;
      #1;
      chk("pass_stall_ready", 64'(p_ir), 64'd0);
      p_iv = 1'b1; p_d = 64'd4; p_or = 1'b1;
      #1;
      chk("pass_through_ready", 64'(p_ir), 64'd1);
      @(posedge clk); #1;
      chk_pass("pass_take4", 1, 64'd4, 1, 1);
      @(negedge clk);
      p_iv = 1'b0; p_or = 1'b1;
      @(posedge clk); #1;
      chk_pass("pass_drain", 0, 64'd0, 0, 1);

      // reset mid-transfer discards a full skid buffer
      @(negedge clk);
      p_or = 1'b0;
      r_iv = 1'b1; r_d = 64'h21; r_or = 1'b0;
      @(posedge clk);
      @(negedge clk);
      r_d = 64'h22;
      @(posedge clk); #1;
      chk_skid("fill_before_reset", 1, 64'h21, 2, 0);
      @(negedge clk);
      reset = 1'b1; r_d = 64'h23; r_or = 1'b1;
      @(posedge clk); #1;
      chk_skid("reset_mid", 0, 64'd0, 0, 1);
      @(negedge clk);
      reset = 1'b0; r_iv = 1'b0; r_or = 1'b1;
      @(posedge clk); #1;
      chk_skid("reset_mid_after", 0, 64'd0, 0, 1);

      // random scoreboard, both modes side by side
      begin
         logic [63:0] nxt1, nxt0;
         logic acc, rel;
         nxt1 = 64'h1000; nxt0 = 64'h2000;
         q1.delete(); q0.delete();
         for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            r_iv = ($urandom_range(0, 3) != 0);
            r_or = ($urandom_range(0, 2) != 0);
            r_fl = ($urandom_range(0, 24) == 0);
            r_d  = nxt1;
            p_iv = ($urandom_range(0, 3) != 0);
            p_or = ($urandom_range(0, 2) != 0);
            p_fl = ($urandom_range(0, 24) == 0);
            p_d  = nxt0;
            #1;
            chk("rnd1_valid", 64'(r_ov), 64'(q1.size() != 0));
            chk("rnd1_count", 64'(r_cnt), 64'(q1.size()));
            chk("rnd1_ready", 64'(r_ir), 64'(q1.size() < 2));
            if (q1.size() != 0) chk("rnd1_data", r_od, q1[0]);
            else                chk("rnd1_bubble", r_od, 64'd0);
            acc = r_iv && r_ir;
            rel = r_ov && r_or;
            if (rel && q1.size() != 0) void'(q1.pop_front());
            if (acc) nxt1 = nxt1 + 1;
            if (r_fl) q1.delete();
            else if (acc) q1.push_back(r_d);

            chk("rnd0_valid", 64'(p_ov), 64'(q0.size() != 0));
            chk("rnd0_count", 64'(p_cnt), 64'(q0.size()));
            chk("rnd0_ready", 64'(p_ir), 64'(q0.size() == 0 || p_or));
            if (q0.size() != 0) chk("rnd0_data", p_od, q0[0]);
            else                chk("rnd0_bubble", p_od, 64'd0);
            acc = p_iv && p_ir;
            rel = p_ov && p_or;
            if (rel && q0.size() != 0) void'(q0.pop_front());
            if (acc) nxt0 = nxt0 + 1;
            if (p_fl) q0.delete();
            else if (acc) q0.push_back(p_d);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
